lcd_bus_driver: RTL and testbench

//  Downstream consumer of the data_gen 9-bit valid/ready word stream (bit 8 = RS, bits 7:0 = byte).

---
 rtl/lcd_bus_driver_pkg.sv | 32 +++
 rtl/lcd_bus_driver_delay_cnt.sv | 23 ++
 rtl/lcd_bus_driver.sv | 126 ++++++++++++
 tb/tb_lcd_bus_driver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_driver_pkg.sv
// Shared definitions for the HD44780 8-bit bus driver: states, word layout, command constants.
package lcd_bus_driver_pkg;

    typedef enum logic [2:0] {
        ST_POR   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_WAIT  = 3'd5
    } lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] db;
    } lcd_word_t;

    localparam logic       RS_CMD    = 1'b0;
    localparam logic       RS_DATA   = 1'b1;
    localparam logic [7:0] LCD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_HOME  = 8'h02;

    function automatic int unsigned cyc_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Clear and both return-home encodings (0x02 and 0x03) need the long execution wait.
    function automatic logic is_long_wait(input lcd_word_t w);
        return (w.rs == RS_CMD) && ((w.db == LCD_CLEAR) || (w.db == LCD_HOME) || (w.db == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_bus_driver_delay_cnt.sv
// Loadable down-counter that parks at zero; zero_o flags the last cycle of a delay.
module lcd_bus_driver_delay_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clock_i) begin
        if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 8-bit write driver: turns each accepted 9-bit word into one timed RS/E/DB bus write.
module lcd_bus_driver
    import lcd_bus_driver_pkg::*;
#(
    parameter int unsigned INIT_WAIT_CYC = 1_500_000,
    parameter int unsigned SETUP_CYC     = 4,
    parameter int unsigned EN_CYC        = 25,
    parameter int unsigned HOLD_CYC      = 2,
    parameter int unsigned CMD_WAIT_CYC  = 4_000,
    parameter int unsigned CLR_WAIT_CYC  = 164_000
) (
    input  logic       clock_i,
    input  logic       rst_i,
    input  logic [8:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_e_o,
    output logic [7:0] lcd_data_o
);

    localparam int unsigned MAX_CYC = cyc_max(cyc_max(cyc_max(INIT_WAIT_CYC, SETUP_CYC),
                                              cyc_max(EN_CYC, HOLD_CYC)),
                                              cyc_max(CMD_WAIT_CYC, CLR_WAIT_CYC));
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    lcd_state_e       state_q, state_d;
    lcd_word_t        word;
    logic             accept;
    logic             cnt_load, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             e_d, rs_d, long_q, long_d;
    logic [7:0]       db_d;

    assign word     = lcd_word_t'(data_i);
    assign lcd_rw_o = 1'b0;

    // The last WAIT cycle doubles as an accept slot so valid-held streams run at the full period.
    assign ready_o = ~rst_i & ((state_q == ST_IDLE) | ((state_q == ST_WAIT) & cnt_zero));
    assign busy_o  = ~ready_o;
    assign accept  = valid_i & ready_o;

    lcd_bus_driver_delay_cnt #(.WIDTH(CNT_W)) u_cnt (
        .clock_i (clock_i),
        .load    (cnt_load),
        .value   (cnt_val),
        .zero_o  (cnt_zero)
    );

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            state_q    <= ST_POR;
            lcd_e_o    <= 1'b0;
            lcd_rs_o   <= 1'b0;
            lcd_data_o <= 8'h00;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lcd_e_o    <= e_d;
            lcd_rs_o   <= rs_d;
            lcd_data_o <= db_d;
            long_q     <= long_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        e_d      = lcd_e_o;
        rs_d     = lcd_rs_o;
        db_d     = lcd_data_o;
        long_d   = long_q;

        case (state_q)
            ST_POR: begin
                if (cnt_zero) state_d = ST_IDLE;
            end
            ST_IDLE: ;
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d  = ST_PULSE;
                    e_d      = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(EN_CYC - 1);
                end
            end
            ST_PULSE: begin
                if (cnt_zero) begin
                    state_d  = ST_HOLD;
                    e_d      = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(HOLD_CYC - 1);
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d  = ST_WAIT;
                    cnt_load = 1'b1;
                    cnt_val  = long_q ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_zero) state_d = ST_IDLE;
            end
            default: state_d = ST_POR;
        endcase

        if (accept) begin
            state_d  = ST_SETUP;
            rs_d     = word.rs;
            db_d     = word.db;
            long_d   = is_long_wait(word);
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(SETUP_CYC - 1);
        end

        if (rst_i) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(INIT_WAIT_CYC - 1);
        end
    end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Scoreboard bench for lcd_bus_driver: accepted words queue expectations, a monitor checks the bus.
module tb_lcd_bus_driver;

    localparam int unsigned INIT = 10;
    localparam int unsigned SETUP = 2;
    localparam int unsigned EN = 3;
    localparam int unsigned HOLD = 1;
    localparam int unsigned CMDW = 5;
    localparam int unsigned CLRW = 20;

    logic       clock_i = 1'b0;
    logic       rst_i;
    logic [8:0] data_i;
    logic       valid_i;
    logic       ready_o, busy_o, lcd_rs_o, lcd_rw_o, lcd_e_o;
    logic [7:0] lcd_data_o;

    lcd_bus_driver #(
        .INIT_WAIT_CYC(INIT), .SETUP_CYC(SETUP), .EN_CYC(EN),
        .HOLD_CYC(HOLD), .CMD_WAIT_CYC(CMDW), .CLR_WAIT_CYC(CLRW)
    ) dut (
        .clock_i(clock_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .busy_o(busy_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o),
        .lcd_e_o(lcd_e_o), .lcd_data_o(lcd_data_o)
    );

    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    int         total = 0, bad = 0;
    logic [8:0] q_word[$];
    int         q_t0[$];
    int         q_rdy[$];
    bit         abort = 0, b2b = 0, prev_e = 0, prev_rdy = 0;
    int         rise_cyc = 0, last_rise = 0, e_count = 0;
    logic [8:0] cur_w = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int period(input logic [8:0] w);
        logic long_w;
        long_w = (w[8] == 1'b0) && (w[7:0] >= 8'h01) && (w[7:0] <= 8'h03);
        return SETUP + EN + HOLD + (long_w ? CLRW : CMDW);
    endfunction

    // Stimulus side: every word the DUT will take on the next edge queues its expectations.
    always @(negedge clock_i) begin
        if (rst_i === 1'b0 && valid_i === 1'b1 && ready_o === 1'b1) begin
            q_word.push_back(data_i);
            q_t0.push_back(cyc + 1);
            q_rdy.push_back(cyc + period(data_i));
        end
    end

    // Monitor side: E pulses and ready returns are matched against the queues.
    always @(negedge clock_i) begin
        if (lcd_e_o === 1'b1 && !prev_e) begin
            e_count++;
            if (q_word.size() == 0) begin
                total++; bad++;
                $display("FAIL e_unexpected: E rose at cycle %0d with no word pending", cyc);
            end else begin
                int t0;
                cur_w = q_word.pop_front();
                t0 = q_t0.pop_front();
                check("rs_at_rise", 32'(lcd_rs_o), 32'(cur_w[8]));
                check("db_at_rise", 32'(lcd_data_o), 32'(cur_w[7:0]));
                check("e_rise_cycle", 32'(cyc), 32'(t0 + SETUP));
                check("rw_low", 32'(lcd_rw_o), 32'd0);
                if (b2b && last_rise > 0) check("b2b_spacing", 32'(cyc - last_rise), 32'd11);
            end
            rise_cyc = cyc;
            last_rise = cyc;
        end
        if (lcd_e_o === 1'b0 && prev_e) begin
            if (abort) begin
                abort = 0;
            end else begin
                check("e_width", 32'(cyc - rise_cyc), 32'(EN));
                check("db_at_fall", 32'({lcd_rs_o, lcd_data_o}), 32'(cur_w));
            end
        end
        prev_e = (lcd_e_o === 1'b1);

        if (ready_o === 1'b1 && !prev_rdy) begin
            if (q_rdy.size() == 0) begin
                total++; bad++;
                $display("FAIL rdy_unexpected: ready rose at cycle %0d with none pending", cyc);
            end else begin
                check("ready_return", 32'(cyc), 32'(q_rdy.pop_front()));
                check("busy_inv", 32'(busy_o), 32'd0);
            end
        end
        prev_rdy = (ready_o === 1'b1);
    end

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        repeat (n) @(posedge clock_i);
        #2;
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd1);
        check("rst_e", 32'(lcd_e_o), 32'd0);
        check("rst_bus", 32'({lcd_rs_o, lcd_data_o}), 32'd0);
        rst_i = 1'b0;
        q_rdy.push_back(cyc + INIT);
    endtask

    task automatic wait_accept();
        int n = 0;
        @(negedge clock_i);
        while (ready_o !== 1'b1 && n < 300) begin
            @(negedge clock_i);
            n++;
        end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL accept_timeout: ready never asserted, ready=%b", ready_o);
        end
        @(posedge clock_i);
        #2;
    endtask

    task automatic send(input logic [8:0] w);
        data_i = w;
        valid_i = 1'b1;
        wait_accept();
    endtask

    task automatic drain();
        int n = 0;
        while ((q_word.size() != 0 || q_rdy.size() != 0) && n < 200) begin
            @(posedge clock_i);
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL drain_timeout: words=%0d readys=%0d pending", q_word.size(), q_rdy.size());
        end
        repeat (3) @(posedge clock_i);
        #2;
    endtask

    logic [8:0] s6[8];

    initial begin
        rst_i = 1'b1;
        valid_i = 1'b1;
        data_i = 9'h138;
        s6 = '{9'h038, 9'h00C, 9'h001, 9'h148, 9'h165, 9'h002, 9'h16C, 9'h180};

        // Power-on wait with valid held, then the held word goes out first.
        do_reset(3);
        wait_accept();
        valid_i = 1'b0;
        drain();

        // Long-wait boundaries and data bytes that look like commands.
        send(9'h001);
        send(9'h101);
        send(9'h002);
        send(9'h003);
        send(9'h004);
        send(9'h000);
        valid_i = 1'b0;
        drain();

        // Valid stuck high across four words.
        b2b = 1; last_rise = 0; e_count = 0;
        send(9'h141);
        send(9'h142);
        send(9'h143);
        send(9'h0C0);
        valid_i = 1'b0;
        drain();
        b2b = 0;
        check("b2b_pulses", 32'(e_count), 32'd4);

        // Reset while E is high aborts the write and restarts the power-on wait.
        send(9'h155);
        valid_i = 1'b0;
        begin
            int n = 0;
            while (lcd_e_o !== 1'b1 && n < 50) begin
                @(posedge clock_i);
                #2;
                n++;
            end
            if (n >= 50) begin
                total++; bad++;
                $display("FAIL e_wait_timeout: E stayed %b", lcd_e_o);
            end
        end
        @(negedge clock_i);
        #1;
        rst_i = 1'b1;
        abort = 1;
        q_rdy.delete();
        @(posedge clock_i);
        #2;
        check("abort_e", 32'(lcd_e_o), 32'd0);
        check("abort_ready", 32'(ready_o), 32'd0);
        do_reset(2);
        send(9'h1AA);
        valid_i = 1'b0;
        drain();

        // Generator-like source with idle gaps and junk data while valid is low.
        e_count = 0;
        for (int i = 0; i < 8; i++) begin
            int gap = int'($urandom_range(0, 12));
            valid_i = 1'b0;
            repeat (gap) begin
                data_i = 9'($urandom);
                @(posedge clock_i);
                #2;
            end
            send(s6[i]);
        end
        valid_i = 1'b0;
        drain();
        check("stream_pulses", 32'(e_count), 32'd8);
        check("final_rw", 32'(lcd_rw_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
